// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: state codes, opcodes,
// ALU_op codes (also used by the ALU control decoder) and datapath mux selects.
package mips_ctrl_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned SEL_W    = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_IMM_EXEC  = 4'd11,
    S_IMM_WB    = 4'd12
  } state_e;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b001100;

  localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [SEL_W-1:0] ALUOP_AND   = 2'b11;

  localparam logic [SEL_W-1:0] ALUSRCB_B       = 2'b00;
  localparam logic [SEL_W-1:0] ALUSRCB_FOUR    = 2'b01;
  localparam logic [SEL_W-1:0] ALUSRCB_IMM     = 2'b10;
  localparam logic [SEL_W-1:0] ALUSRCB_IMM_SH2 = 2'b11;

  localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic             pc_write;
    logic             pc_write_cond;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             ir_write;
    logic             reg_write;
    logic             reg_dst;
    logic             alu_src_a;
    logic             ext_zero;
    logic [SEL_W-1:0] pc_source;
    logic [SEL_W-1:0] alu_src_b;
    logic [SEL_W-1:0] alu_op;
    logic             instr_done;
    logic             illegal_op;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control/datapath boundary: opcode and memory handshake in, datapath controls out.
interface multicycle_control_if;
  import mips_ctrl_pkg::*;

  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                PCWrite;
  logic                PCWriteCond;
  logic                IorD;
  logic                MemRead;
  logic                MemWrite;
  logic                MemtoReg;
  logic                IRWrite;
  logic                RegWrite;
  logic                RegDst;
  logic                ALUSrcA;
  logic                ext_zero;
  logic [SEL_W-1:0]    PCSource;
  logic [SEL_W-1:0]    ALUSrcB;
  logic [SEL_W-1:0]    ALU_op;
  logic                instr_done;
  logic                illegal_op;
  logic [STATE_W-1:0]  state;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           RegWrite, RegDst, ALUSrcA, ext_zero, PCSource, ALUSrcB, ALU_op,
           instr_done, illegal_op, state
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           RegWrite, RegDst, ALUSrcA, ext_zero, PCSource, ALUSrcB, ALU_op,
           instr_done, illegal_op, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS core. Outputs are a combinational decode
// of the state register so that reset clears every enable immediately.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);

  state_e r_state;
  state_e w_next_state;
  ctrl_t  w_ctl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state decode; unused codes 13-15 fall back to IDLE.
  always_comb begin
    w_next_state = S_IDLE;
    case (r_state)
      S_IDLE:      w_next_state = S_FETCH;
      S_FETCH:     w_next_state = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:         w_next_state = S_EXECUTE;
          OP_LW, OP_SW:     w_next_state = S_MEM_ADDR;
          OP_BEQ:           w_next_state = S_BRANCH;
          OP_J:             w_next_state = S_JUMP;
          OP_ADDI, OP_ANDI: w_next_state = S_IMM_EXEC;
          default:          w_next_state = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        if (bus.opcode == OP_SW)      w_next_state = S_MEM_WRITE;
        else if (bus.opcode == OP_LW) w_next_state = S_MEM_READ;
        else                          w_next_state = S_FETCH;
      end
      S_MEM_READ:  w_next_state = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    w_next_state = S_FETCH;
      S_MEM_WRITE: w_next_state = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   w_next_state = S_R_WB;
      S_R_WB:      w_next_state = S_FETCH;
      S_BRANCH:    w_next_state = S_FETCH;
      S_JUMP:      w_next_state = S_FETCH;
      S_IMM_EXEC:  w_next_state = S_IMM_WB;
      S_IMM_WB:    w_next_state = S_FETCH;
      default:     w_next_state = S_IDLE;
    endcase
  end

  // Output decode; anything not set for a state stays 0.
  always_comb begin
    w_ctl = '0;
    case (r_state)
      S_FETCH: begin
        w_ctl.mem_read  = 1'b1;
        w_ctl.alu_src_b = ALUSRCB_FOUR;
        w_ctl.alu_op    = ALUOP_ADD;
        w_ctl.pc_source = PCSRC_ALU;
        w_ctl.ir_write  = bus.mem_ready;
        w_ctl.pc_write  = bus.mem_ready;
      end
      S_DECODE: begin
        w_ctl.alu_src_b = ALUSRCB_IMM_SH2;
        w_ctl.alu_op    = ALUOP_ADD;
        case (bus.opcode)
          OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI: w_ctl.illegal_op = 1'b0;
          default:                                                w_ctl.illegal_op = 1'b1;
        endcase
      end
      S_MEM_ADDR: begin
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_src_b = ALUSRCB_IMM;
        w_ctl.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        w_ctl.mem_read = 1'b1;
        w_ctl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        w_ctl.reg_write  = 1'b1;
        w_ctl.mem_to_reg = 1'b1;
        w_ctl.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        w_ctl.mem_write  = 1'b1;
        w_ctl.i_or_d     = 1'b1;
        w_ctl.instr_done = bus.mem_ready;
      end
      S_EXECUTE: begin
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_src_b = ALUSRCB_B;
        w_ctl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        w_ctl.reg_write  = 1'b1;
        w_ctl.reg_dst    = 1'b1;
        w_ctl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        w_ctl.alu_src_a     = 1'b1;
        w_ctl.alu_src_b     = ALUSRCB_B;
        w_ctl.alu_op        = ALUOP_SUB;
        w_ctl.pc_write_cond = 1'b1;
        w_ctl.pc_source     = PCSRC_ALUOUT;
        w_ctl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        w_ctl.pc_write   = 1'b1;
        w_ctl.pc_source  = PCSRC_JUMP;
        w_ctl.instr_done = 1'b1;
      end
      S_IMM_EXEC: begin
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_src_b = ALUSRCB_IMM;
        if (bus.opcode == OP_ANDI) begin
          w_ctl.alu_op   = ALUOP_AND;
          w_ctl.ext_zero = 1'b1;
        end else begin
          w_ctl.alu_op   = ALUOP_ADD;
          w_ctl.ext_zero = 1'b0;
        end
      end
      S_IMM_WB: begin
        w_ctl.reg_write  = 1'b1;
        w_ctl.instr_done = 1'b1;
      end
      default: w_ctl = '0;
    endcase
  end

  assign bus.PCWrite     = w_ctl.pc_write;
  assign bus.PCWriteCond = w_ctl.pc_write_cond;
  assign bus.IorD        = w_ctl.i_or_d;
  assign bus.MemRead     = w_ctl.mem_read;
  assign bus.MemWrite    = w_ctl.mem_write;
  assign bus.MemtoReg    = w_ctl.mem_to_reg;
  assign bus.IRWrite     = w_ctl.ir_write;
  assign bus.RegWrite    = w_ctl.reg_write;
  assign bus.RegDst      = w_ctl.reg_dst;
  assign bus.ALUSrcA     = w_ctl.alu_src_a;
  assign bus.ext_zero    = w_ctl.ext_zero;
  assign bus.PCSource    = w_ctl.pc_source;
  assign bus.ALUSrcB     = w_ctl.alu_src_b;
  assign bus.ALU_op      = w_ctl.alu_op;
  assign bus.instr_done  = w_ctl.instr_done;
  assign bus.illegal_op  = w_ctl.illegal_op;
  assign bus.state       = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class cycle by
// cycle and compares state plus every control output against hand-built vectors.
module tb_multicycle_control;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   irw_cnt;

  multicycle_control_if u_if ();

  multicycle_control u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout: PCWrite PCWriteCond IorD MemRead MemWrite MemtoReg IRWrite
  //                RegWrite RegDst ALUSrcA ext_zero PCSource[2] ALUSrcB[2] ALU_op[2] instr_done illegal_op
  localparam logic [18:0] E_ZERO       = '0;
  localparam logic [18:0] E_FETCH_WAIT = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b00,1'b0,1'b0};
  localparam logic [18:0] E_FETCH_RDY  = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b00,1'b0,1'b0};
  localparam logic [18:0] E_DECODE     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b11,2'b00,1'b0,1'b0};
  localparam logic [18:0] E_DECODE_ILL = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b11,2'b00,1'b0,1'b1};
  localparam logic [18:0] E_MEM_ADDR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b10,2'b00,1'b0,1'b0};
  localparam logic [18:0] E_MEM_READ   = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
  localparam logic [18:0] E_MEM_WB     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
  localparam logic [18:0] E_MW_WAIT    = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
  localparam logic [18:0] E_MW_RDY     = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
  localparam logic [18:0] E_EXECUTE    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b10,1'b0,1'b0};
  localparam logic [18:0] E_R_WB       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
  localparam logic [18:0] E_BRANCH     = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b01,2'b00,2'b01,1'b1,1'b0};
  localparam logic [18:0] E_JUMP       = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b00,1'b1,1'b0};
  localparam logic [18:0] E_ADDI       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b10,2'b00,1'b0,1'b0};
  localparam logic [18:0] E_ANDI       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,2'b00,2'b10,2'b11,1'b0,1'b0};
  localparam logic [18:0] E_IMM_WB     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};

  function automatic logic [18:0] obs_vec();
    return {u_if.PCWrite, u_if.PCWriteCond, u_if.IorD, u_if.MemRead, u_if.MemWrite,
            u_if.MemtoReg, u_if.IRWrite, u_if.RegWrite, u_if.RegDst, u_if.ALUSrcA,
            u_if.ext_zero, u_if.PCSource, u_if.ALUSrcB, u_if.ALU_op,
            u_if.instr_done, u_if.illegal_op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: entered at posedge+1, drives mem_ready, checks, advances.
  task automatic cyc(input string tag, input logic rdy, input logic [3:0] exp_state,
                     input logic [18:0] exp_vec);
    u_if.mem_ready = rdy;
    #2;
    chk({tag, ".state"}, 32'(u_if.state), 32'(exp_state));
    chk({tag, ".ctl"}, 32'(obs_vec()), 32'(exp_vec));
    if (u_if.IRWrite === 1'b1) irw_cnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    irw_cnt        = 0;
    rst_n          = 1'b0;
    u_if.opcode    = 6'b000000;
    u_if.mem_ready = 1'b1;

    // Held in reset across edges
    #22;
    chk("reset.state", 32'(u_if.state), 32'd0);
    chk("reset.ctl", 32'(obs_vec()), 32'(E_ZERO));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release.state", 32'(u_if.state), 32'd0);
    @(posedge clk);
    #1;

    // R-type, zero wait
    u_if.opcode = 6'b000000;
    cyc("rt.fetch", 1'b1, 4'd1, E_FETCH_RDY);
    cyc("rt.decode", 1'b1, 4'd2, E_DECODE);
    cyc("rt.exec", 1'b1, 4'd7, E_EXECUTE);
    cyc("rt.wb", 1'b1, 4'd8, E_R_WB);

    // lw: 2 fetch waits + 3 read waits = 10 cycles
    u_if.opcode = 6'b100011;
    irw_cnt = 0;
    cyc("lw.fetch_w0", 1'b0, 4'd1, E_FETCH_WAIT);
    cyc("lw.fetch_w1", 1'b0, 4'd1, E_FETCH_WAIT);
    cyc("lw.fetch", 1'b1, 4'd1, E_FETCH_RDY);
    cyc("lw.decode", 1'b0, 4'd2, E_DECODE);
    cyc("lw.addr", 1'b0, 4'd3, E_MEM_ADDR);
    cyc("lw.read_w0", 1'b0, 4'd4, E_MEM_READ);
    cyc("lw.read_w1", 1'b0, 4'd4, E_MEM_READ);
    cyc("lw.read_w2", 1'b0, 4'd4, E_MEM_READ);
    cyc("lw.read", 1'b1, 4'd4, E_MEM_READ);
    cyc("lw.wb", 1'b0, 4'd5, E_MEM_WB);
    chk("lw.irwrite_count", 32'(irw_cnt), 32'd1);

    // sw with one write wait
    u_if.opcode = 6'b101011;
    cyc("sw.fetch", 1'b1, 4'd1, E_FETCH_RDY);
    cyc("sw.decode", 1'b1, 4'd2, E_DECODE);
    cyc("sw.addr", 1'b1, 4'd3, E_MEM_ADDR);
    cyc("sw.write_w0", 1'b0, 4'd6, E_MW_WAIT);
    cyc("sw.write", 1'b1, 4'd6, E_MW_RDY);

    // beq
    u_if.opcode = 6'b000100;
    cyc("beq.fetch", 1'b1, 4'd1, E_FETCH_RDY);
    cyc("beq.decode", 1'b1, 4'd2, E_DECODE);
    cyc("beq.branch", 1'b1, 4'd9, E_BRANCH);

    // j
    u_if.opcode = 6'b000010;
    cyc("j.fetch", 1'b1, 4'd1, E_FETCH_RDY);
    cyc("j.decode", 1'b1, 4'd2, E_DECODE);
    cyc("j.jump", 1'b1, 4'd10, E_JUMP);

    // andi
    u_if.opcode = 6'b001100;
    cyc("andi.fetch", 1'b1, 4'd1, E_FETCH_RDY);
    cyc("andi.decode", 1'b1, 4'd2, E_DECODE);
    cyc("andi.exec", 1'b1, 4'd11, E_ANDI);
    cyc("andi.wb", 1'b1, 4'd12, E_IMM_WB);

    // addi
    u_if.opcode = 6'b001000;
    cyc("addi.fetch", 1'b1, 4'd1, E_FETCH_RDY);
    cyc("addi.decode", 1'b1, 4'd2, E_DECODE);
    cyc("addi.exec", 1'b1, 4'd11, E_ADDI);
    cyc("addi.wb", 1'b1, 4'd12, E_IMM_WB);

    // Illegal opcode: pulse in DECODE, straight back to FETCH
    u_if.opcode = 6'b111111;
    cyc("ill.fetch", 1'b1, 4'd1, E_FETCH_RDY);
    cyc("ill.decode", 1'b1, 4'd2, E_DECODE_ILL);

    // R-type aborted by reset during EXECUTE
    u_if.opcode = 6'b000000;
    cyc("abort.fetch", 1'b1, 4'd1, E_FETCH_RDY);
    cyc("abort.decode", 1'b1, 4'd2, E_DECODE);
    #2;
    chk("abort.exec_state", 32'(u_if.state), 32'd7);
    rst_n = 1'b0;
    #1;
    chk("abort.reset_state", 32'(u_if.state), 32'd0);
    chk("abort.reset_ctl", 32'(obs_vec()), 32'(E_ZERO));
    @(posedge clk);
    #1;
    chk("abort.held_ctl", 32'(obs_vec()), 32'(E_ZERO));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort.release_state", 32'(u_if.state), 32'd0);
    @(posedge clk);
    #1;
    cyc("abort.refetch", 1'b0, 4'd1, E_FETCH_WAIT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle MIPS core. It sequences fetch, decode, execute, memory and write-back for R-type, lw, sw, beq, j, addi and andi. It drives every datapath enable and mux select, and produces the 2-bit `ALU_op` consumed by the downstream ALU control decoder. It stalls on a single-bit memory ready handshake.

## Interface
- No parameters; encodings are fixed in the shared package.
- `clk`  in  1  system clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `opcode`  in  6  IR[31:26]; stable from the cycle after IR write
- `mem_ready`  in  1  memory completes the current MemRead/MemWrite this cycle
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `RegWrite`, `RegDst`, `ALUSrcA`, `ext_zero`  out  1 each  datapath controls (`ext_zero`: zero-extend immediate)
- `PCSource`  out  2  00 ALU result, 01 ALUOut, 10 jump target
- `ALUSrcB`  out  2  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2
- `ALU_op`  out  2  00 add, 01 sub, 10 use funct, 11 and
- `instr_done`  out  1  one-cycle pulse in the final cycle of each legal instruction
- `illegal_op`  out  1  one-cycle pulse in DECODE for an unsupported opcode
- `state`  out  4  current state, for debug

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXECUTE=7, R_WB=8, BRANCH=9, JUMP=10, IMM_EXEC=11, IMM_WB=12. Codes 13–15 go to IDLE.
- Outputs are a pure decode of `state`, plus `mem_ready` and `opcode` where noted. Any output not listed for a state is 0.
- IDLE: all outputs 0. Next state is FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_op=00, PCSource=00. IRWrite=PCWrite=`mem_ready`. Stays in FETCH while `mem_ready`=0; goes to DECODE when `mem_ready`=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALU_op=00. Next state by opcode:
  - 000000 → EXECUTE
  - 100011 or 101011 → MEM_ADDR
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000 or 001100 → IMM_EXEC
  - any other opcode → FETCH, with `illegal_op`=1
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALU_op=00. lw → MEM_READ; sw → MEM_WRITE.
- MEM_READ: MemRead=1, IorD=1. Holds until `mem_ready`, then → MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0, `instr_done`=1. Next state is FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Holds until `mem_ready`; then `instr_done`=1 and → FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALU_op=10. Next state is R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=0, `instr_done`=1. Next state is FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALU_op=01, PCWriteCond=1, PCSource=01, `instr_done`=1. Next state is FETCH.
- JUMP: PCWrite=1, PCSource=10, `instr_done`=1. Next state is FETCH.
- IMM_EXEC: ALUSrcA=1, ALUSrcB=10. For addi: ALU_op=00, ext_zero=0. For andi: ALU_op=11, ext_zero=1. Next state is IMM_WB.
- IMM_WB: RegWrite=1, RegDst=0, MemtoReg=0, `instr_done`=1. Next state is FETCH.
- `mem_ready` is ignored outside FETCH, MEM_READ and MEM_WRITE.
- MemRead/MemWrite are held steady for the whole wait. IRWrite/PCWrite never assert in a FETCH cycle with `mem_ready`=0.

## Timing
- Reset: `rst_n`=0 forces `state`=IDLE immediately, so every output is 0 asynchronously. Reset mid-instruction aborts it with no partial write-enable afterwards.
- First FETCH is the first rising edge after `rst_n` rises.
- Cycle counts with zero-wait memory (`mem_ready`=1):
  - lw: 5
  - sw, R-type, addi, andi: 4
  - beq, j: 3
  - illegal opcode: 2
- Each wait cycle at FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- `instr_done` and `illegal_op` never assert in the same cycle. Both are single-cycle pulses.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - state codes
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI)
  - ALU_op codes (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT, ALUOP_AND), reused by the ALU control decoder
  - ALUSrcB and PCSource codes
- Single module; no sub-module is warranted. Next-state and output decode are two combinational blocks beside one state register.

## Test plan
- Reset with `rst_n`=0 mid-EXECUTE → `state`=0 and all outputs 0 within the same cycle; after release, IDLE→FETCH.
- R-type (opcode 000000), `mem_ready`=1 → states 1,2,7,8. ALU_op=10 in state 7. RegWrite=RegDst=1 and `instr_done`=1 in state 8.
- lw (100011) with `mem_ready` low for 2 cycles in FETCH and 3 in MEM_READ → 10 cycles total. IRWrite is asserted exactly once; MemtoReg=1 in MEM_WB.
- beq (000100) → ALU_op=01, PCWriteCond=1, PCSource=01 in BRANCH. j (000010) → PCWrite=1, PCSource=10.
- andi (001100) → ALU_op=11 and ext_zero=1 in IMM_EXEC. addi (001000) → ALU_op=00 and ext_zero=0.
- Opcode 111111 → `illegal_op` pulses in DECODE, no register or memory write occurs, and FETCH follows.
